// File: rtl/datapath_mc.sv
// datapath_mc - width-generic multi-cycle CPU datapath.
//   Holds PC, SP, LR, IR, MDR, registered ALU result, NZCV flags and an
//   8-entry register file. A small memory-read FSM raises MemReq and Stall
//   while a read is outstanding. All architectural writes are suppressed
//   until MemAck returns the data.
// Ports:
//   Clock, nReset             clock, synchronous active-low reset
//   DataIn, MemAck, MemStart  memory read data, data valid, start a read
//   AluOp..WdSel, SpOp        datapath steering from the control FSM
//   *We                       register write enables (masked by Stall)
//   PcEn/LrEn/AluEn/SpEn      SysBus drive enables (at most one high)
//   CFlag                     ALU carry-in
//   SysBus                    tristate bus; MemReq/MemDone/Stall are the read handshake
//   Opcode = Ir[15:8], Flags = registered {N,Z,C,V}

package opcodes;
  typedef enum logic [2:0] {AluAdd, AluAdc, AluSub, AluSbc, AluAnd, AluOr, AluXor, AluPassB} alu_functions_t;
  typedef enum logic [1:0] {PcLr, PcAluRes, PcMdr, PcInc} pc_select_t;
  typedef enum logic [1:0] {Op1Rd1, Op1Pc, Op1Sp, Op1Zero} Op1_select_t;
  typedef enum logic {Op2Rd2, Op2Extended} Op2_select_t;
  typedef enum logic {ImmShort, ImmLong} Imm_select_t;
  typedef enum logic {WdAlu, WdSys} Wd_select_t;
endpackage

// alu - DW-bit ALU with N/Z/C/V.
//   Subtraction is a + ~b + carry-in. C is the raw carry out, so C=1 means "no borrow".
//   Logic ops and pass-b clear C and V.
module alu import opcodes::*; #(
  parameter int DW = 16
) (
  input  alu_functions_t fn,
  input  logic [DW-1:0]  a,
  input  logic [DW-1:0]  b,
  input  logic           cin,
  output logic [DW-1:0]  res,
  output logic [3:0]     flags
);
  logic [DW-1:0] b_eff;
  logic [DW:0]   sum;
  logic          carry_in, c, v;

  always_comb begin
    b_eff    = b;
    carry_in = 1'b0;
    case (fn)
      AluAdc:  carry_in = cin;
      AluSub:  begin b_eff = ~b; carry_in = 1'b1; end
      AluSbc:  begin b_eff = ~b; carry_in = cin;  end
      default: ;
    endcase
    sum = {1'b0, a} + {1'b0, b_eff} + (DW+1)'(carry_in);
    res = sum[DW-1:0];
    c   = sum[DW];
    v   = (a[DW-1] == b_eff[DW-1]) && (sum[DW-1] != a[DW-1]);
    case (fn)
      AluAnd:   begin res = a & b; c = 1'b0; v = 1'b0; end
      AluOr:    begin res = a | b; c = 1'b0; v = 1'b0; end
      AluXor:   begin res = a ^ b; c = 1'b0; v = 1'b0; end
      AluPassB: begin res = b;     c = 1'b0; v = 1'b0; end
      default:  ;
    endcase
  end

  assign flags = {res[DW-1], (res == '0), c, v};
endmodule

// Memory read FSM:
//   state  | meaning
//   S_IDLE | no read outstanding; MemStart launches one
//   S_WAIT | MemReq/Stall high; MemAck captures DataIn into Mdr
module datapath_mc import opcodes::*; #(
  parameter int            DW       = 16,
  parameter logic [DW-1:0] PC_RESET = '0,
  parameter logic [DW-1:0] SP_RESET = '1
) (
  input  logic           Clock,
  input  logic           nReset,
  input  logic [DW-1:0]  DataIn,
  input  logic           MemAck,
  input  logic           MemStart,
  input  alu_functions_t AluOp,
  input  pc_select_t     PcSel,
  input  Op1_select_t    Op1Sel,
  input  Op2_select_t    Op2Sel,
  input  Imm_select_t    ImmSel,
  input  Wd_select_t     WdSel,
  input  logic [1:0]     SpOp,
  input  logic           PcWe,
  input  logic           LrWe,
  input  logic           IrWe,
  input  logic           RegWe,
  input  logic           AluWe,
  input  logic           FlagWe,
  input  logic           PcEn,
  input  logic           LrEn,
  input  logic           AluEn,
  input  logic           SpEn,
  input  logic           CFlag,
  output logic [DW-1:0]  SysBus,
  output logic           MemReq,
  output logic           MemDone,
  output logic           Stall,
  output logic [7:0]     Opcode,
  output logic [3:0]     Flags
);
  typedef enum logic {S_IDLE, S_WAIT} mem_state_t;

  mem_state_t    state, state_nx;
  logic          ack_take;
  logic [DW-1:0] pc, sp, lr, aluout, mdr;
  logic [15:0]   ir;
  logic [3:0]    flags_q, alu_flags;
  logic [DW-1:0] rf [8];
  logic [DW-1:0] rd1, rd2, imm, op1, op2, alu_res, wd, pc_nx, bus_val;
  logic          bus_en;

  always_ff @(posedge Clock) begin
    if (!nReset) state <= S_IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    MemReq   = 1'b0;
    Stall    = 1'b0;
    ack_take = 1'b0;
    case (state)
      S_IDLE: if (MemStart) state_nx = S_WAIT;
      S_WAIT: begin
        MemReq   = 1'b1;
        Stall    = 1'b1;
        ack_take = MemAck;
        if (MemAck) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  assign rd1 = rf[ir[10:8]];
  assign rd2 = rf[ir[4:2]];
  assign imm = (ImmSel == ImmShort) ? {{(DW-5){ir[4]}}, ir[4:0]}
                                    : {{(DW-8){ir[7]}}, ir[7:0]};

  always_comb begin
    op1 = '0;
    case (Op1Sel)
      Op1Rd1:  op1 = rd1;
      Op1Pc:   op1 = pc;
      Op1Sp:   op1 = sp;
      default: op1 = '0;
    endcase
    op2 = (Op2Sel == Op2Extended) ? imm : rd2;
    wd  = (WdSel == WdSys) ? mdr : alu_res;
    pc_nx = pc + DW'(1);
    case (PcSel)
      PcLr:     pc_nx = lr;
      PcAluRes: pc_nx = alu_res;
      PcMdr:    pc_nx = mdr;
      default:  pc_nx = pc + DW'(1);
    endcase
  end

  alu #(.DW(DW)) u_alu (
    .fn    (AluOp),
    .a     (op1),
    .b     (op2),
    .cin   (CFlag),
    .res   (alu_res),
    .flags (alu_flags)
  );

  // The read handshake (Mdr, MemDone) keeps running during a stall.
  // Only the control-driven writes are gated by Stall.
  always_ff @(posedge Clock) begin
    if (!nReset) begin
      pc      <= PC_RESET;
      sp      <= SP_RESET;
      lr      <= '0;
      ir      <= '0;
      aluout  <= '0;
      mdr     <= '0;
      flags_q <= '0;
      MemDone <= 1'b0;
      for (int i = 0; i < 8; i++) rf[i] <= '0;
    end else begin
      MemDone <= ack_take;
      if (ack_take) mdr <= DataIn;
      if (!Stall) begin
        if (PcWe)   pc      <= pc_nx;
        if (LrWe)   lr      <= pc;
        if (IrWe)   ir      <= mdr[15:0];
        if (RegWe)  rf[ir[10:8]] <= wd;
        if (AluWe)  aluout  <= alu_res;
        if (FlagWe) flags_q <= alu_flags;
        case (SpOp)
          2'b01:   sp <= sp - DW'(1);
          2'b10:   sp <= sp + DW'(1);
          2'b11:   sp <= alu_res;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    bus_val = '0;
    if (PcEn)       bus_val = pc;
    else if (LrEn)  bus_val = lr;
    else if (AluEn) bus_val = aluout;
    else if (SpEn)  bus_val = sp;
  end

  assign bus_en = PcEn | LrEn | AluEn | SpEn;
  assign SysBus = bus_en ? bus_val : 'z;
  assign Opcode = ir[15:8];
  assign Flags  = flags_q;
endmodule
